eqchk_sched: RTL and testbench

- Round-robin scheduler that shares one six-input dual-output equivalence datapath (inputs a..f, outputs o1/o2) between N_REQ requesters.
- Each transaction runs as: grant one requester, latch its 6-bit operand vector, drive the datapath for LAT cycles, sample o1/o2, then return the result with a mismatch flag over a valid/ready response channel.
- Keeps a saturating count of o1 != o2 events for the formal and simulation benches to observe.

---
 rtl/eqchk_sched_if.sv | 36 +++
 rtl/eqchk_sched.sv | 135 +++++++++++++
 tb/tb_eqchk_sched.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eqchk_sched_if.sv
// Requester, datapath and response signals of the equivalence-check scheduler.
interface eqchk_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [6*N_REQ-1:0] req_vec;
    logic [N_REQ-1:0]   gnt;
    logic [5:0]         dut_in;
    logic               dut_o1;
    logic               dut_o2;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic               rsp_o1;
    logic               rsp_o2;
    logic               rsp_mismatch;
    logic [CNT_W-1:0]   mismatch_cnt;
    logic               busy;

    modport master (
        output req, req_vec, dut_o1, dut_o2, rsp_ready,
        input  gnt, dut_in, rsp_valid, rsp_id,
        input  rsp_o1, rsp_o2, rsp_mismatch,
        input  mismatch_cnt, busy
    );

    modport slave (
        input  req, req_vec, dut_o1, dut_o2, rsp_ready,
        output gnt, dut_in, rsp_valid, rsp_id,
        output rsp_o1, rsp_o2, rsp_mismatch,
        output mismatch_cnt, busy
    );
endinterface

// File: rtl/eqchk_sched.sv
// Round-robin scheduler sharing one 6-in/2-out equivalence datapath
// between N_REQ requesters, with a saturating o1 != o2 counter.
module eqchk_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input logic         clk,
    input logic         rst,
    eqchk_sched_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [5:0]       op_q, op_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    id_q, id_d;
    logic             o1_q, o1_d;
    logic             o2_q, o2_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IW:0]      sum;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    win;
    logic             found;

    // first requester at or after rr_q, wrapping modulo N_REQ
    always_comb begin
        sum   = '0;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            idx = sum[IW-1:0];
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        wcnt_d  = wcnt_q;
        op_d    = op_q;
        gnt_d   = '0;
        id_d    = id_q;
        o1_d    = o1_q;
        o2_d    = o2_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = DRIVE;
                    gnt_d[win] = 1'b1;
                    op_d       = bus.req_vec[int'(win)*6 +: 6];
                    id_d       = win;
                    wcnt_d     = '0;
                end
            end
            DRIVE: begin
                if (wcnt_q == WW'(LAT-1)) begin
                    state_d = RESP;
                    o1_d    = bus.dut_o1;
                    o2_d    = bus.dut_o2;
                    mis_d   = bus.dut_o1 ^ bus.dut_o2;
                    if ((bus.dut_o1 ^ bus.dut_o2) && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rr_d    = (id_q == IW'(N_REQ-1)) ? '0 : id_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            wcnt_q  <= '0;
            op_q    <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            o1_q    <= 1'b0;
            o2_q    <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            wcnt_q  <= wcnt_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            o1_q    <= o1_d;
            o2_q    <= o2_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.dut_in       = op_q;
    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_o1       = o1_q;
    assign bus.rsp_o2       = o2_q;
    assign bus.rsp_mismatch = mis_q;
    assign bus.mismatch_cnt = cnt_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_eqchk_sched.sv
// Bench for eqchk_sched: LAT=1 instance for arbitration and counting,
// LAT=3 instance for latency, mid-transaction reset and ignored pulses.
module tb_eqchk_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst3 = 1'b1;
    logic [1:0] mode = 2'd0;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    eqchk_sched_if #(.N_REQ(4), .CNT_W(8)) bus ();
    eqchk_sched_if #(.N_REQ(4), .CNT_W(8)) bus3 ();

    eqchk_sched #(.N_REQ(4), .LAT(1), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    eqchk_sched #(.N_REQ(4), .LAT(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst(rst3), .bus(bus3)
    );

    // datapath stub: mode 0 equivalent, 1 forced 1/0, 2 o2 flips with a
    function automatic logic f1(input logic [5:0] x, input logic [1:0] m);
        if (m == 2'd1) return 1'b1;
        return (x[0] & x[1]) | (x[2] & x[3]) | (x[4] & x[5]);
    endfunction

    function automatic logic f2(input logic [5:0] x, input logic [1:0] m);
        if (m == 2'd1) return 1'b0;
        if (m == 2'd2) return f1(x, 2'd0) ^ x[0];
        return ~(~(x[0] & x[1]) & ~(x[2] & x[3]) & ~(x[4] & x[5]));
    endfunction

    assign bus.dut_o1  = f1(bus.dut_in, mode);
    assign bus.dut_o2  = f2(bus.dut_in, mode);
    assign bus3.dut_o1 = f1(bus3.dut_in, mode);
    assign bus3.dut_o2 = f2(bus3.dut_in, mode);

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [23:0] vec;
        logic [1:0]  mode;
        logic [1:0]  id;
        logic [5:0]  din;
        logic        o1;
        logic        o2;
        logic        mis;
    } vec_t;

    vec_t tbl[9];

    task automatic run_txn(input int i);
        int n;
        mode           = tbl[i].mode;
        bus.req_vec    = tbl[i].vec;
        bus.req        = tbl[i].req;
        bus.rsp_ready  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == 4'd0 && n < 10);
        chk($sformatf("t%0d_gnt_lat", i), n, 1);
        chk($sformatf("t%0d_gnt_din", i), {bus.gnt, bus.dut_in},
            {4'b0001 << tbl[i].id, tbl[i].din});
        bus.req = 4'd0;
        @(negedge clk);
        chk($sformatf("t%0d_rsp", i),
            {bus.rsp_valid, bus.rsp_id, bus.rsp_o1, bus.rsp_o2,
             bus.rsp_mismatch, bus.gnt},
            {1'b1, tbl[i].id, tbl[i].o1, tbl[i].o2, tbl[i].mis, 4'd0});
        @(negedge clk);
        chk($sformatf("t%0d_drop", i), {bus.rsp_valid, bus.busy}, 2'b00);
    endtask

    task automatic wait_gnt3(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus3.gnt == 4'd0 && n < 12);
    endtask

    // invariants on the LAT=1 instance, sampled just after each negedge
    initial begin : monitor
        logic pv, pr, pb;
        logic [5:0] pdin;
        pv = 0; pr = 0; pb = 0; pdin = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pv = 0; pr = 0; pb = 0;
            end else begin
                chk("gnt_onehot0", $onehot0(bus.gnt), 1);
                if (pv && !pr) chk("valid_hold", bus.rsp_valid, 1);
                if (pb && bus.busy) chk("din_stable", bus.dut_in, pdin);
                chk("busy_state", bus.busy, u_dut.state_q != 0);
                pv = bus.rsp_valid;
                pr = bus.rsp_ready;
                pb = bus.busy;
                pdin = bus.dut_in;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout compared=%0d", compared);
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, g, last, bad, spur, nrsp;
        logic [11:0] snap;

        tbl[0] = '{4'b0001, {6'h00, 6'h00, 6'h00, 6'h2A}, 2'd0, 2'd0, 6'h2A, 0, 0, 0};
        tbl[1] = '{4'b0001, {6'h00, 6'h00, 6'h00, 6'h03}, 2'd0, 2'd0, 6'h03, 1, 1, 0};
        tbl[2] = '{4'b1001, {6'h0C, 6'h00, 6'h00, 6'h3F}, 2'd0, 2'd3, 6'h0C, 1, 1, 0};
        tbl[3] = '{4'b1001, {6'h0C, 6'h00, 6'h00, 6'h3F}, 2'd0, 2'd0, 6'h3F, 1, 1, 0};
        tbl[4] = '{4'b0100, {6'h00, 6'h21, 6'h00, 6'h00}, 2'd2, 2'd2, 6'h21, 0, 1, 1};
        tbl[5] = '{4'b0010, {6'h00, 6'h00, 6'h30, 6'h00}, 2'd2, 2'd1, 6'h30, 1, 1, 0};
        tbl[6] = '{4'b0110, {6'h00, 6'h15, 6'h2A, 6'h00}, 2'd1, 2'd2, 6'h15, 1, 0, 1};
        tbl[7] = '{4'b1110, {6'h1C, 6'h3F, 6'h05, 6'h00}, 2'd0, 2'd3, 6'h1C, 1, 1, 0};
        tbl[8] = '{4'b1110, {6'h1C, 6'h3F, 6'h05, 6'h00}, 2'd0, 2'd1, 6'h05, 0, 0, 0};

        bus.req = '0; bus.req_vec = '0; bus.rsp_ready = 1'b1;
        bus3.req = '0; bus3.req_vec = '0; bus3.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state",
            {bus.gnt, bus.dut_in, bus.rsp_valid, bus.rsp_id, bus.rsp_o1,
             bus.rsp_o2, bus.rsp_mismatch, bus.mismatch_cnt, bus.busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        rst3 = 1'b0;

        for (int i = 0; i < 9; i++) run_txn(i);
        chk("table_cnt", bus.mismatch_cnt, 2);
        chk("dut_in_hold_idle", bus.dut_in, 6'h05);

        // continuous requests from all four: strict rotation every LAT+2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mode = 2'd0;
        bus.req_vec = {6'h0C, 6'h3F, 6'h03, 6'h2A};
        bus.req = 4'hF;
        g = 0; last = 0;
        for (int cyc = 0; cyc < 60 && g < 8; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) chk("rr_rsp_id", bus.rsp_id, (g - 1) % 4);
            if (bus.gnt != 4'd0) begin
                chk("rr_order", bus.gnt, 4'b0001 << (g % 4));
                if (g > 0) chk("rr_spacing", cyc - last, 3);
                last = cyc;
                g++;
            end
        end
        chk("rr_count", g, 8);
        bus.req = 4'd0;
        @(negedge clk);
        chk("rr_last_rsp", {bus.rsp_valid, bus.rsp_id}, {1'b1, 2'd3});
        @(negedge clk);

        // forced mismatch: counter saturates at 255
        mode = 2'd1;
        bus.req_vec = '0;
        bus.req = 4'b0001;
        n = 0; bad = 0;
        for (int cyc = 0; cyc < 1500 && n < 300; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                n++;
                if (!bus.rsp_mismatch) bad++;
                if (n == 254 || n == 255 || n == 256 || n == 300)
                    chk($sformatf("sat_cnt_%0d", n), bus.mismatch_cnt,
                        (n > 255) ? 255 : n);
            end
        end
        bus.req = 4'd0;
        chk("sat_txns", n, 300);
        chk("sat_mis_every", bad, 0);
        @(negedge clk);
        mode = 2'd0;

        // back-pressure with requests pending; pointer now at 1
        bus.rsp_ready = 1'b0;
        bus.req_vec = {6'h00, 6'h0C, 6'h03, 6'h00};
        bus.req = 4'b0110;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == 4'd0 && n < 10);
        chk("bp_gnt", bus.gnt, 4'b0010);
        @(negedge clk);
        snap = {bus.rsp_valid, bus.rsp_id, bus.rsp_o1, bus.rsp_o2,
                bus.rsp_mismatch, bus.dut_in};
        chk("bp_rsp", snap, {1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 6'h03});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_%0d", k),
                {bus.rsp_valid, bus.rsp_id, bus.rsp_o1, bus.rsp_o2,
                 bus.rsp_mismatch, bus.dut_in, bus.gnt},
                {1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 6'h03, 4'd0});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", bus.rsp_valid, 0);
        @(negedge clk);
        chk("bp_next_gnt", {bus.gnt, bus.dut_in}, {4'b0100, 6'h0C});
        bus.req = 4'd0;
        repeat (2) @(negedge clk);

        // LAT=3: latency, then reset in DRIVE
        mode = 2'd1;
        bus3.req_vec = {6'h00, 6'h03, 6'h00, 6'h00};
        bus3.req = 4'b0100;
        wait_gnt3(n);
        chk("l3_gnt", bus3.gnt, 4'b0100);
        bus3.req = 4'd0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("l3_valid_%0d", k), bus3.rsp_valid, k == 3);
        end
        chk("l3_rsp",
            {bus3.rsp_id, bus3.rsp_o1, bus3.rsp_o2, bus3.rsp_mismatch,
             bus3.mismatch_cnt}, {2'd2, 1'b1, 1'b0, 1'b1, 8'd1});
        @(negedge clk);
        mode = 2'd0;
        bus3.req_vec = {6'h00, 6'h00, 6'h00, 6'h3F};
        bus3.req = 4'b0001;
        wait_gnt3(n);
        chk("l3_gnt2", bus3.gnt, 4'b0001);
        bus3.req = 4'd0;
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        chk("l3_rst_outputs",
            {bus3.gnt, bus3.dut_in, bus3.rsp_valid, bus3.rsp_id,
             bus3.rsp_o1, bus3.rsp_o2, bus3.rsp_mismatch,
             bus3.mismatch_cnt, bus3.busy}, 0);
        @(negedge clk);
        rst3 = 1'b0;
        nrsp = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus3.rsp_valid || bus3.gnt != 4'd0) nrsp++;
        end
        chk("l3_no_rsp_after_rst", nrsp, 0);
        bus3.req_vec = {6'h0C, 6'h00, 6'h00, 6'h2A};
        bus3.req = 4'b1001;
        wait_gnt3(n);
        chk("l3_fresh_gnt", bus3.gnt, 4'b0001);
        bus3.req = 4'd0;

        // req[2] pulse during DRIVE must be ignored
        @(negedge clk);
        bus3.req = 4'b0100;
        @(negedge clk);
        bus3.req = 4'd0;
        spur = 0; nrsp = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus3.gnt != 4'd0) spur++;
            if (bus3.rsp_valid) begin
                nrsp++;
                chk("pulse_rsp_id", bus3.rsp_id, 0);
            end
        end
        chk("pulse_no_gnt", spur, 0);
        chk("pulse_one_rsp", nrsp, 1);
        chk("pulse_idle", bus3.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
